rv32i_trace_buffer: RTL and testbench
=====================================

// Module: rv32i_trace_buffer
// PURPOSE
//  Synthesizable execution-trace capture buffer for the RV32I core; the on-chip successor to per-cycle register dumps.
//  Per-cycle samples are logged into a circular buffer: PC, ALU result, data-memory read, rd index and wb enable.
//  A PC-match trigger or a stop pulse freezes capture; the buffer is then drained oldest-first over a valid/ready port.
//  Sits beside the RV32I top and is fed directly from core wires.
// PARAMETERS
//  XLEN       32  datapath width of pc/alu/mem sample fields
//  DEPTH      16  trace entries; power of 2, >=4
//  POST_TRIG  4   samples captured after (not incl.) trigger sample; 0..DEPTH-1
//  FILTER_WB  0   1: record only samples with cap_wb_en=1; 0: record every cap_valid sample
// PORTS
//  top_clk    in   1             system clock, all logic on rising edge
//  top_rst    in   1             reset, synchronous, active-low
//  cap_valid  in   1             core sample qualifier (instruction advanced this cycle)
//  cap_pc     in   XLEN          PC of sample
//  cap_alu    in   XLEN          ALU output of sample
//  cap_mem    in   XLEN          data-memory read of sample
//  cap_rd     in   5             destination register index
//  cap_wb_en  in   1             register write enable
//  arm        in   1             pulse: clear buffer, enter ARMED
//  stop       in   1             pulse: end capture immediately (ARMED/POST -> DONE)
//  trig_en    in   1             enable PC-match trigger
//  trig_pc    in   XLEN          trigger PC
//  rd_valid   out  1             rd_data holds an unread entry
//  rd_ready   in   1             consumer accepts entry
//  rd_data    out  3*XLEN+6      {pc, alu, mem, rd[4:0], wb_en}, oldest first
//  state      out  2             0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  count      out  clog2(DEPTH)+1 valid entries held
//  wrapped    out  1             oldest data overwritten since last arm
//  done_pulse out  1             one-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (top_rst=0 at edge): state=IDLE, wr_ptr=rd_ptr=0, count=0, wrapped=0, done_pulse=0; rd_valid=0. Entry RAM not cleared.
//  Accepted sample: cap_valid && (!FILTER_WB || cap_wb_en) && state in {ARMED, POST}; written at wr_ptr on that edge, count visible next cycle.
//  Write: wr_ptr+1 mod DEPTH. If count==DEPTH: overwrite oldest, rd_ptr+1 mod DEPTH, count unchanged, wrapped<=1.
//  IDLE: samples ignored. arm -> ARMED.
//  ARMED: accept samples. Accepted sample with trig_en && cap_pc==trig_pc is written;
//    then POST_TRIG==0 -> DONE, else post_cnt<=POST_TRIG, -> POST.
//  POST: each accepted sample decrements post_cnt; sample taking post_cnt 1->0 is written, -> DONE. Trigger matches ignored.
//  DONE: no capture. rd_valid = (count!=0); rd_data = entry[rd_ptr] (combinational read).
//    rd_valid&&rd_ready: rd_ptr+1, count-1. Last entry popped -> IDLE next cycle.
//    rd_ready with rd_valid=0 is a no-op. rd_data stable while rd_valid&&!rd_ready.
//  stop in ARMED/POST: -> DONE; a sample accepted the same cycle is still written. stop in IDLE/DONE ignored.
//  arm in any state: pointers/count/wrapped/post_cnt cleared, -> ARMED; same-cycle sample and pop discarded. arm beats stop.
//  done_pulse=1 for exactly the cycle after DONE entry (registered).
//  DONE entered with count==0 (stop before any sample): -> IDLE next cycle, rd_valid never asserted.
//  Reset mid-operation from any state returns to reset values next edge; no partial readout.
//  Width rules: count saturates at DEPTH; post_cnt width clog2(DEPTH); PC compare full XLEN equality.
// TESTING
//  T1 reset: top_rst=0 for 3 cycles mid-POST -> state=0, count=0, rd_valid=0, wrapped=0.
//  T2 DEPTH=8,POST_TRIG=2: arm, cap_valid every cycle with pc 0x00,0x04,..; trig_pc=0x24 -> DONE after pc 0x2C, count=8, wrapped=1, drain gives pc 0x10..0x2C in order, then IDLE.
//  T3 FILTER_WB=1: 6 samples, wb_en alternating 1,0 -> count=3, only wb_en=1 entries read back.
//  T4 backpressure: DONE with 4 entries, rd_ready=0 3 cycles -> rd_data constant, count=4; rd_ready=1 -> one pop/cycle, count 3,2,1,0.
//  T5 stop after 3 samples in ARMED -> done_pulse one cycle, count=3, wrapped=0; stop with 0 samples -> IDLE, rd_valid stays 0.
//  T6 arm in DONE same cycle as rd_ready=1 and cap_valid=1 -> state=ARMED, count=0, no pop, sample dropped.

Source files
------------

// File: rtl/rv32i_trace_buffer.sv
// Execution-trace capture buffer for the RV32I core: logs per-cycle samples into a circular
// buffer, freezes on a PC-match trigger (plus POST_TRIG samples) or stop, then drains oldest-first.
module rv32i_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int FILTER_WB = 0
) (
  input  logic                     top_clk,
  input  logic                     top_rst,
  input  logic                     cap_valid,
  input  logic [XLEN-1:0]          cap_pc,
  input  logic [XLEN-1:0]          cap_alu,
  input  logic [XLEN-1:0]          cap_mem,
  input  logic [4:0]               cap_rd,
  input  logic                     cap_wb_en,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [3*XLEN+5:0]        rd_data,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrapped,
  output logic                     done_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3*XLEN+6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   post_cnt_q, post_cnt_d;
  logic [AW:0]     count_q, count_d;
  logic            wrapped_q, wrapped_d;
  logic            done_pulse_q, done_pulse_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            capturing, accept, pop, trig_hit, full;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    capturing    = (state_q == ST_ARMED) || (state_q == ST_POST);
    accept       = capturing && cap_valid && ((FILTER_WB == 0) || cap_wb_en) && !arm;
    pop          = (state_q == ST_DONE) && (count_q != '0) && rd_ready && !arm;
    trig_hit     = accept && (state_q == ST_ARMED) && trig_en && (cap_pc == trig_pc);
    full         = (count_q == (AW+1)'(DEPTH));

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    post_cnt_d   = post_cnt_q;
    count_d      = count_q;
    wrapped_d    = wrapped_q;

    // A write into a full buffer drops the oldest entry instead of growing the count.
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        wrapped_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end

    case (state_q)
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (trig_hit) begin
          if (POST_TRIG == 0) begin
            state_d = ST_DONE;
          end else begin
            post_cnt_d = AW'(POST_TRIG);
            state_d    = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (accept) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == AW'(1)) state_d = ST_DONE;
        end
        if (stop) state_d = ST_DONE;
      end
      ST_DONE: begin
        if ((count_q == '0) || (pop && (count_q == (AW+1)'(1)))) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Arm overrides everything else in flight, including stop, pop and capture.
    if (arm) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      wrapped_d  = 1'b0;
      post_cnt_d = '0;
      state_d    = ST_ARMED;
    end

    done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge top_clk) begin
    if (!top_rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      post_cnt_q   <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      post_cnt_q   <= post_cnt_d;
      count_q      <= count_d;
      wrapped_q    <= wrapped_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // NOTE: the entry RAM has no reset; count/pointers define which entries are meaningful.
  always_ff @(posedge top_clk) begin
    if (accept) mem_q[wr_ptr_q] <= {cap_pc, cap_alu, cap_mem, cap_rd, cap_wb_en};
  end

  assign state      = state_q;
  assign count      = count_q;
  assign wrapped    = wrapped_q;
  assign done_pulse = done_pulse_q;
  assign rd_valid   = (state_q == ST_DONE) && (count_q != '0);
  assign rd_data    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// Directed bench for rv32i_trace_buffer: an unfiltered and a wb-filtered instance share stimulus,
// expected values are hand-derived from the sample sequence each test drives.
module tb_rv32i_trace_buffer;

  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  localparam int EW = 3*XLEN+6;
  localparam int CW = $clog2(DEPTH)+1;

  logic            top_clk = 1'b0;
  logic            top_rst = 1'b0;
  logic            cap_valid = 1'b0;
  logic [XLEN-1:0] cap_pc = '0, cap_alu = '0, cap_mem = '0, trig_pc = '0;
  logic [4:0]      cap_rd = '0;
  logic            cap_wb_en = 1'b0, arm = 1'b0, stop = 1'b0, trig_en = 1'b0, rd_ready = 1'b0;

  logic            rd_valid, f_rd_valid;
  logic [EW-1:0]   rd_data, f_rd_data;
  logic [1:0]      state, f_state;
  logic [CW-1:0]   count, f_count;
  logic            wrapped, f_wrapped, done_pulse, f_done_pulse;

  int checks = 0;
  int failures = 0;

  always #5 top_clk = ~top_clk;

  rv32i_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(2), .FILTER_WB(0)) dut (
    .top_clk(top_clk), .top_rst(top_rst), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_alu(cap_alu), .cap_mem(cap_mem), .cap_rd(cap_rd), .cap_wb_en(cap_wb_en),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .state(state), .count(count),
    .wrapped(wrapped), .done_pulse(done_pulse)
  );

  rv32i_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(2), .FILTER_WB(1)) dut_f (
    .top_clk(top_clk), .top_rst(top_rst), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_alu(cap_alu), .cap_mem(cap_mem), .cap_rd(cap_rd), .cap_wb_en(cap_wb_en),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc), .rd_valid(f_rd_valid),
    .rd_ready(rd_ready), .rd_data(f_rd_data), .state(f_state), .count(f_count),
    .wrapped(f_wrapped), .done_pulse(f_done_pulse)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge top_clk);
    #1;
  endtask

  // Sample i at pc: alu/mem/rd derived from pc and i; wb_en alternates 1,0 starting with 1.
  function automatic logic [EW-1:0] exp_entry(input logic [31:0] pc, input int i);
    logic [4:0] rd;
    logic       wb;
    rd = 5'(i + 1);
    wb = ~i[0];
    return {pc, pc ^ 32'hA5A5_0000, ~pc, rd, wb};
  endfunction

  task automatic send(input logic [31:0] pc, input int i);
    logic [EW-1:0] e;
    e = exp_entry(pc, i);
    cap_valid = 1'b1;
    cap_pc    = e[EW-1 -: XLEN];
    cap_alu   = e[EW-1-XLEN -: XLEN];
    cap_mem   = e[EW-1-2*XLEN -: XLEN];
    cap_rd    = e[5:1];
    cap_wb_en = e[0];
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_state", 128'(state), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_wrapped", 128'(wrapped), 128'(0));
    check("rst_done_pulse", 128'(done_pulse), 128'(0));
    top_rst = 1'b1;
    tick();
    check("idle_hold", 128'(state), 128'(0));

    // T2: wrap-around, trigger at 0x24 then two post samples
    do_arm();
    check("t2_armed", 128'(state), 128'(1));
    trig_en = 1'b1;
    trig_pc = 32'h24;
    for (int i = 0; i < 12; i++) begin
      send(32'(4*i), i);
      if (i == 8) check("t2_pre_trig", 128'(state), 128'(1));
      if (i == 9) check("t2_post_a", 128'(state), 128'(2));
      if (i == 10) check("t2_post_b", 128'(state), 128'(2));
    end
    trig_en = 1'b0;
    check("t2_done", 128'(state), 128'(3));
    check("t2_done_pulse", 128'(done_pulse), 128'(1));
    check("t2_count", 128'(count), 128'(8));
    check("t2_wrapped", 128'(wrapped), 128'(1));
    tick();
    check("t2_pulse_off", 128'(done_pulse), 128'(0));
    check("t2_still_done", 128'(state), 128'(3));
    rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_rd_valid", 128'(rd_valid), 128'(1));
      check("t2_rd_data", 128'(rd_data), 128'(exp_entry(32'(32'h10 + 4*k), 4 + k)));
      tick();
    end
    rd_ready = 1'b0;
    check("t2_idle", 128'(state), 128'(0));
    check("t2_empty", 128'(count), 128'(0));
    check("t2_rd_valid_off", 128'(rd_valid), 128'(0));

    // T4: backpressure with four entries
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h104;
    for (int i = 0; i < 4; i++) send(32'(32'h100 + 4*i), i);
    trig_en = 1'b0;
    check("t4_done", 128'(state), 128'(3));
    check("t4_count", 128'(count), 128'(4));
    check("t4_wrapped", 128'(wrapped), 128'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_data", 128'(rd_data), 128'(exp_entry(32'h100, 0)));
      check("t4_hold_count", 128'(count), 128'(4));
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_pop_data", 128'(rd_data), 128'(exp_entry(32'(32'h100 + 4*k), k)));
      tick();
      check("t4_pop_count", 128'(count), 128'(3 - k));
    end
    check("t4_idle", 128'(state), 128'(0));
    tick();
    check("t4_noop_count", 128'(count), 128'(0));
    check("t4_noop_state", 128'(state), 128'(0));
    rd_ready = 1'b0;

    // T1: reset mid-POST after a wrap
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h24;
    for (int i = 0; i < 10; i++) send(32'(4*i), i);
    trig_en = 1'b0;
    check("t1_in_post", 128'(state), 128'(2));
    check("t1_wrapped_pre", 128'(wrapped), 128'(1));
    top_rst = 1'b0;
    tick(); tick(); tick();
    top_rst = 1'b1;
    check("t1_state", 128'(state), 128'(0));
    check("t1_count", 128'(count), 128'(0));
    check("t1_rd_valid", 128'(rd_valid), 128'(0));
    check("t1_wrapped", 128'(wrapped), 128'(0));
    check("t1_f_state", 128'(f_state), 128'(0));

    // T3: wb filter keeps only wb_en=1 samples
    do_arm();
    for (int i = 0; i < 6; i++) send(32'(32'h200 + 4*i), i);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_f_done", 128'(f_state), 128'(3));
    check("t3_f_count", 128'(f_count), 128'(3));
    check("t3_unfiltered_count", 128'(count), 128'(6));
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t3_f_rd_data", 128'(f_rd_data), 128'(exp_entry(32'(32'h200 + 8*k), 2*k)));
      tick();
    end
    check("t3_f_idle", 128'(f_state), 128'(0));
    check("t3_f_rd_valid", 128'(f_rd_valid), 128'(0));
    check("t3_unf_count", 128'(count), 128'(3));
    tick(); tick(); tick();
    rd_ready = 1'b0;
    check("t3_unf_idle", 128'(state), 128'(0));

    // T5: stop after three samples in ARMED
    do_arm();
    for (int i = 0; i < 3; i++) send(32'(32'h300 + 4*i), i);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_done", 128'(state), 128'(3));
    check("t5_done_pulse", 128'(done_pulse), 128'(1));
    check("t5_count", 128'(count), 128'(3));
    check("t5_wrapped", 128'(wrapped), 128'(0));
    tick();
    check("t5_pulse_off", 128'(done_pulse), 128'(0));
    check("t5_count_hold", 128'(count), 128'(3));

    // T6: arm in DONE together with rd_ready and a sample
    arm = 1'b1;
    rd_ready = 1'b1;
    cap_valid = 1'b1;
    cap_pc = 32'h400;
    cap_wb_en = 1'b1;
    tick();
    arm = 1'b0;
    rd_ready = 1'b0;
    cap_valid = 1'b0;
    check("t6_armed", 128'(state), 128'(1));
    check("t6_count", 128'(count), 128'(0));
    check("t6_rd_valid", 128'(rd_valid), 128'(0));

    // T5b: stop with no samples falls straight back to IDLE
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5b_done", 128'(state), 128'(3));
    check("t5b_pulse", 128'(done_pulse), 128'(1));
    check("t5b_count", 128'(count), 128'(0));
    check("t5b_rd_valid", 128'(rd_valid), 128'(0));
    tick();
    check("t5b_idle", 128'(state), 128'(0));
    check("t5b_rd_valid_idle", 128'(rd_valid), 128'(0));

    // stop and samples in IDLE are ignored
    stop = 1'b1;
    cap_valid = 1'b1;
    tick();
    stop = 1'b0;
    cap_valid = 1'b0;
    check("idle_stop_state", 128'(state), 128'(0));
    check("idle_sample_count", 128'(count), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
